crf_stack_engine: RTL

Parametrised dual-stack engine for the crforth core. It holds the parameter stack and the return stack in dedicated on-chip registers instead of memory addressed through PSP/RSP. It executes one stack primitive per accepted request under a valid/ready handshake, with a single clock and no phase divisor. Overflow, underflow and illegal opcodes are detected before execution and trap the engine into a fault state; software (the control unit) recovers through an explicit clear.

---
 rtl/crf_stack_engine_if.sv | 30 +++
 rtl/crf_stack_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/crf_stack_engine_if.sv
// Request/response bundle between the crforth control unit and the stack engine.
interface crf_stack_engine_if #(
    parameter int WIDTH  = 16,
    parameter int PDEPTH = 16,
    parameter int RDEPTH = 16
);
    logic                        i_VALID;
    logic                        o_READY;
    logic [3:0]                  i_OP;
    logic [WIDTH-1:0]            i_DATA;
    logic                        i_CLRERR;
    logic                        o_ACK;
    logic [WIDTH-1:0]            o_TOS;
    logic [WIDTH-1:0]            o_NOS;
    logic [WIDTH-1:0]            o_RTOS;
    logic [$clog2(PDEPTH+1)-1:0] o_PCOUNT;
    logic [$clog2(RDEPTH+1)-1:0] o_RCOUNT;
    logic                        o_FAULT;
    logic [2:0]                  o_ERRCODE;

    modport master (
        output i_VALID, i_OP, i_DATA, i_CLRERR,
        input  o_READY, o_ACK, o_TOS, o_NOS, o_RTOS, o_PCOUNT, o_RCOUNT, o_FAULT, o_ERRCODE
    );

    modport slave (
        input  i_VALID, i_OP, i_DATA, i_CLRERR,
        output o_READY, o_ACK, o_TOS, o_NOS, o_RTOS, o_PCOUNT, o_RCOUNT, o_FAULT, o_ERRCODE
    );
endinterface

// File: rtl/crf_stack_engine.sv
// Register-based parameter/return stack engine for the crforth core.
// One primitive per accepted request; prechecked faults trap into FAULT
// until the control unit pulses i_CLRERR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | accepting requests (unless i_CLRERR is high)
// ST_FAULT | trapped on a precheck failure, waiting for i_CLRERR
module crf_stack_engine #(
    parameter int WIDTH  = 16,
    parameter int PDEPTH = 16,
    parameter int RDEPTH = 16
) (
    input  logic               i_CLOCK,
    input  logic               i_RESET_N,
    crf_stack_engine_if.slave  bus
);
    localparam int PCW = $clog2(PDEPTH+1);
    localparam int RCW = $clog2(RDEPTH+1);
    localparam int PAW = $clog2(PDEPTH);
    localparam int RAW = $clog2(RDEPTH);

    localparam logic [3:0] OP_PUSH = 4'd1,  OP_DROP  = 4'd2,  OP_DUP   = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4,  OP_OVER  = 4'd5,  OP_TOR   = 4'd6;
    localparam logic [3:0] OP_FROMR = 4'd7, OP_RPUSH = 4'd8,  OP_RDROP = 4'd9;
    localparam logic [3:0] OP_REPL = 4'd10, OP_BINRES = 4'd11, OP_CLEAR = 4'd12;

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [WIDTH-1:0]  pstk [PDEPTH];
    logic [WIDTH-1:0]  rstk [RDEPTH];
    logic [PCW-1:0]    pcount_q;
    logic [RCW-1:0]    rcount_q;
    logic [2:0]        err_q, err_d, err_chk;
    logic              ack_q, ack_d;
    logic              accept, exec, clr;
    logic [PAW-1:0]    p_idx, p_m1, p_m2;
    logic [RAW-1:0]    r_idx, r_m1;

    assign p_idx = pcount_q[PAW-1:0];
    assign p_m1  = p_idx - PAW'(1);
    assign p_m2  = p_idx - PAW'(2);
    assign r_idx = rcount_q[RAW-1:0];
    assign r_m1  = r_idx - RAW'(1);

    assign bus.o_READY   = (state_q == ST_RUN) && !bus.i_CLRERR;
    assign accept        = bus.i_VALID && bus.o_READY;
    assign bus.o_ACK     = ack_q;
    assign bus.o_FAULT   = (state_q == ST_FAULT);
    assign bus.o_ERRCODE = err_q;
    assign bus.o_PCOUNT  = pcount_q;
    assign bus.o_RCOUNT  = rcount_q;
    assign bus.o_TOS     = (pcount_q != '0)      ? pstk[p_m1] : '0;
    assign bus.o_NOS     = (pcount_q >= PCW'(2)) ? pstk[p_m2] : '0;
    assign bus.o_RTOS    = (rcount_q != '0)      ? rstk[r_m1] : '0;

    // Reset asserts asynchronously, releases two clocks after i_RESET_N rises.
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Precheck: the first failing rule in priority order names the fault.
    always_comb begin
        err_chk = 3'd0;
        if (bus.i_OP > OP_CLEAR)
            err_chk = 3'd5;
        else if (((bus.i_OP inside {OP_DROP, OP_DUP, OP_TOR, OP_REPL}) && pcount_q == '0) ||
                 ((bus.i_OP inside {OP_SWAP, OP_OVER, OP_BINRES}) && pcount_q < PCW'(2)))
            err_chk = 3'd1;
        else if ((bus.i_OP inside {OP_PUSH, OP_DUP, OP_OVER, OP_FROMR}) && pcount_q == PCW'(PDEPTH))
            err_chk = 3'd2;
        else if ((bus.i_OP inside {OP_FROMR, OP_RDROP}) && rcount_q == '0)
            err_chk = 3'd3;
        else if ((bus.i_OP inside {OP_TOR, OP_RPUSH}) && rcount_q == RCW'(RDEPTH))
            err_chk = 3'd4;
    end

    // State, fault code and ack registers.
    always_ff @(posedge i_CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            err_q   <= 3'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    // Next state: clear beats any request; a failing precheck traps instead of executing.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        exec    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.i_CLRERR) begin
                    clr   = 1'b1;
                    err_d = 3'd0;
                end else if (accept) begin
                    if (err_chk != 3'd0) begin
                        state_d = ST_FAULT;
                        err_d   = err_chk;
                    end else begin
                        exec  = 1'b1;
                        ack_d = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.i_CLRERR) begin
                    state_d = ST_RUN;
                    err_d   = 3'd0;
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Stack storage and depths; clearing only resets the depths.
    always_ff @(posedge i_CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            pcount_q <= '0;
            rcount_q <= '0;
            for (int i = 0; i < PDEPTH; i++) pstk[i] <= '0;
            for (int i = 0; i < RDEPTH; i++) rstk[i] <= '0;
        end else if (clr) begin
            pcount_q <= '0;
            rcount_q <= '0;
        end else if (exec) begin
            case (bus.i_OP)
                OP_PUSH: begin
                    pstk[p_idx] <= bus.i_DATA;
                    pcount_q    <= pcount_q + PCW'(1);
                end
                OP_DROP: pcount_q <= pcount_q - PCW'(1);
                OP_DUP: begin
                    pstk[p_idx] <= pstk[p_m1];
                    pcount_q    <= pcount_q + PCW'(1);
                end
                OP_SWAP: begin
                    pstk[p_m1] <= pstk[p_m2];
                    pstk[p_m2] <= pstk[p_m1];
                end
                OP_OVER: begin
                    pstk[p_idx] <= pstk[p_m2];
                    pcount_q    <= pcount_q + PCW'(1);
                end
                OP_TOR: begin
                    rstk[r_idx] <= pstk[p_m1];
                    pcount_q    <= pcount_q - PCW'(1);
                    rcount_q    <= rcount_q + RCW'(1);
                end
                OP_FROMR: begin
                    pstk[p_idx] <= rstk[r_m1];
                    pcount_q    <= pcount_q + PCW'(1);
                    rcount_q    <= rcount_q - RCW'(1);
                end
                OP_RPUSH: begin
                    rstk[r_idx] <= bus.i_DATA;
                    rcount_q    <= rcount_q + RCW'(1);
                end
                OP_RDROP: rcount_q <= rcount_q - RCW'(1);
                OP_REPL:  pstk[p_m1] <= bus.i_DATA;
                OP_BINRES: begin
                    pstk[p_m2] <= bus.i_DATA;
                    pcount_q   <= pcount_q - PCW'(1);
                end
                OP_CLEAR: begin
                    pcount_q <= '0;
                    rcount_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
